// File: rtl/conv_window_feeder_if.sv
// conv_window_feeder_if
// Groups the two streams around the window feeder:
//   input stream : in_valid, in_data, in_last  -> feeder;  in_ready  <- feeder
//   window stream: A, out_valid, out_last, err <- feeder;  out_ready -> feeder
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both 1; valid, data and last stay stable until then.
// Modports:
//   slave  - the feeder itself
//   master - the environment (sample source and window consumer)
interface conv_window_feeder_if #(
    parameter int bw     = 8,
    parameter int rows   = 8,
    parameter int height = 2
);
    logic                       in_valid;
    logic [bw-1:0]              in_data;
    logic                       in_last;
    logic                       in_ready;
    logic [rows*bw*height-1:0]  A;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;
    logic                       err;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, A, out_valid, out_last, err
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, A, out_valid, out_last, err
    );
endinterface

// File: rtl/conv_window_feeder.sv
// conv_window_feeder
// Collects a stream of bw-bit samples into rows of `rows` samples and keeps a
// sliding window of the last `height` rows (row 0 oldest, in the low bits of A).
// Each completed row is committed into the window; once `height` rows of the
// current frame are present, every commit presents a new window on A.
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-low reset
//   bus     - slave side of conv_window_feeder_if (sample and window streams)
//   state_o - FSM state: 0 FILL, 1 EMIT, 2 STALL
module conv_window_feeder #(
    parameter int bw     = 8,
    parameter int rows   = 8,
    parameter int height = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_window_feeder_if.slave   bus,
    output logic [1:0]            state_o
);
    localparam int RW = rows * bw;
    localparam int WW = RW * height;
    localparam int CW = (rows > 1) ? $clog2(rows) : 1;
    localparam int HW = $clog2(height + 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        EMIT  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   col_q;
    logic [HW-1:0]   row_cnt_q;
    logic [RW-1:0]   asm_q;
    logic [RW-1:0]   asm_d;
    logic [WW-1:0]   win_q;
    logic [WW-1:0]   win_d;
    logic            out_valid_q;
    logic            out_last_q;
    logic            err_q;
    logic            row_pend_q;
    logic            pend_last_q;

    logic            accept;
    logic            col_end;
    logic            complete;
    logic            misplaced;
    logic            blocked;
    logic            commit;
    logic            commit_last;
    logic [HW-1:0]   row_sat;
    logic            fills;

    assign accept      = bus.in_valid & ~row_pend_q;
    assign col_end     = (col_q == CW'(rows - 1));
    assign complete    = accept & col_end;
    assign misplaced   = accept & bus.in_last & ~col_end;
    // The window must not move while a presented window is still untaken.
    assign blocked     = out_valid_q & ~bus.out_ready;
    assign commit      = (complete | row_pend_q) & ~blocked;
    assign commit_last = row_pend_q ? pend_last_q : bus.in_last;
    assign row_sat     = (row_cnt_q == HW'(height)) ? row_cnt_q : HW'(row_cnt_q + 1'b1);
    assign fills       = commit & (row_sat == HW'(height));

    // Assembly row including the sample accepted this cycle, so a completing
    // sample commits together with the rest of its row on the same edge.
    always_comb begin
        asm_d = asm_q;
        if (accept) begin
            asm_d[int'(col_q)*bw +: bw] = bus.in_data;
        end
    end

    // Window shift: row 0 drops out, the new row lands in the top slot.
    always_comb begin
        win_d = win_q;
        if (commit) begin
            for (int r = 0; r < height - 1; r++) begin
                win_d[r*RW +: RW] = win_q[(r+1)*RW +: RW];
            end
            win_d[(height-1)*RW +: RW] = asm_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            col_q       <= '0;
            row_cnt_q   <= '0;
            asm_q       <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            row_pend_q  <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            asm_q <= asm_d;
            win_q <= win_d;
            err_q <= misplaced;

            // Any in_last (legal or misplaced) restarts the column count.
            if (accept) begin
                col_q <= (col_end | bus.in_last) ? '0 : CW'(col_q + 1'b1);
            end

            if (complete & blocked) begin
                row_pend_q  <= 1'b1;
                pend_last_q <= bus.in_last;
            end else if (commit) begin
                row_pend_q  <= 1'b0;
                pend_last_q <= 1'b0;
            end

            if (misplaced) begin
                row_cnt_q <= '0;
            end else if (commit) begin
                row_cnt_q <= commit_last ? '0 : row_sat;
            end

            if (fills) begin
                out_valid_q <= 1'b1;
                out_last_q  <= commit_last;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end

            case (state_q)
                FILL: begin
                    if (fills) state_q <= EMIT;
                end
                EMIT: begin
                    if (complete & blocked)          state_q <= STALL;
                    else if (bus.out_ready & ~fills) state_q <= FILL;
                end
                STALL: begin
                    // A held row after a misplaced in_last may commit without
                    // forming a window; the handoff then leaves nothing valid.
                    if (commit) state_q <= fills ? EMIT : FILL;
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.in_ready  = ~row_pend_q;
    assign bus.A         = win_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.err       = err_q;
    assign state_o       = state_q;
endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Upstream feeder for the 1-D convolution filter. Accepts a stream of `bw`-bit activation samples, one per cycle, with a valid/ready handshake. Assembles them into rows of `rows` samples and keeps a sliding window of the last `height` rows. Presents each complete window as the flat `A` bus the filter consumes, with a valid/ready handshake and a vertical stride of 1 row.

## Interface
- `bw`, 8, bits per sample
- `rows`, 8, samples per row
- `height`, 2, rows per window (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `in_valid` in 1: `in_data` valid
- `in_data` in `bw`: activation sample
- `in_last` in 1: frame end, qualified by `in_valid`
- `in_ready` out 1: feeder accepts the sample this cycle
- `A` out `rows*bw*height`: window; row r at `A[r*rows*bw +: rows*bw]`, row 0 oldest; sample c at `+ c*bw`
- `out_valid` out 1: `A` holds a complete window
- `out_ready` in 1: consumer takes the window
- `out_last` out 1: window contains the frame's final row
- `err` out 1: one-cycle pulse on a misplaced `in_last`

## Operation
- **Acceptance:** a sample is accepted when `in_valid & in_ready`. It is written into the assembly row at `col_cnt`, then `col_cnt` increments. `col_cnt` wraps from `rows-1` to 0.
- **Row completion:** accepting the sample at `col_cnt==rows-1` completes the row.
- **Commit:** a completed row shifts into the window: row 0 is dropped, rows move down by one, and the new row becomes row `height-1`. `row_cnt` increments, saturating at `height`.
- **Commit is blocked** if `out_valid & ~out_ready` at that edge. In that case the assembly row is held, `row_pend` is set, and `in_ready` drops to 0. The held row commits on the first edge where `out_valid` is 0 or `out_ready` is 1.
- **Window emission:** `out_valid` is set on the commit edge that makes `row_cnt==height`. It is set on every later commit in the same frame.
- **Window handoff:** `out_valid` clears on an edge with `out_ready`, unless a commit occurs on that same edge. A commit on that edge loads the new window and keeps `out_valid` at 1.
- **`in_ready` rule:** `in_ready = ~row_pend`. A stalled row pends for at most one window handoff.
- **Frame end, legal:** `in_last` with the `col_cnt==rows-1` sample commits that row as usual.
  - The window produced by that commit carries `out_last=1`.
  - `row_cnt` and `col_cnt` then clear, so the next frame needs `height` fresh rows before emitting.
  - If that commit yields no window (`row_cnt<height`), the rows are discarded silently.
- **Frame end, misplaced:** `in_last` at `col_cnt!=rows-1` accepts the sample, then discards the partial row. It clears `col_cnt` and `row_cnt`, and pulses `err` the next cycle. A window already presented stays valid until taken.
- **States:**
  - FILL: `row_cnt<height`, no window pending
  - EMIT: `out_valid=1`
  - STALL: `row_pend=1`
  - Transitions: FILL→EMIT on the filling commit; EMIT→FILL on handoff with no commit; EMIT→STALL on completion while blocked; STALL→EMIT on handoff (held row commits).
- **Window storage:** `A` is driven only from registers, and only window storage drives it.

## Timing
- **Reset** (asynchronous, `rst=0`), all regardless of clock:
  - `out_valid=0`, `out_last=0`, `err=0`, `A=0`, `in_ready=1`
  - counters and `row_pend` cleared
- **Latency:** `out_valid` rises the cycle after the edge accepting the final sample of the `height`-th row.
- **Throughput:** 1 sample/cycle with `out_ready` held at 1. One window every `rows` cycles in steady state.
- **Stability:** `A` and `out_last` are stable while `out_valid & ~out_ready`.
- **Reset mid-operation:** any partial row or pending window is lost. The first window after release needs `height*rows` new samples.

## Test plan
- **Reset:** assert `rst=0` mid-stream with `out_valid=1` → `out_valid=0`, `A=0`, `in_ready=1` immediately; after release, first window only after 16 samples.
- **First window:** feed samples 1..16 back-to-back with `out_ready=1` → `out_valid` rises one cycle after sample 16 is accepted; `A[7:0]=1`, `A[63:56]=8`, `A[71:64]=9`, `A[127:120]=16`.
- **Slide:** continue with 17..24 → second window has row0=9..16 and row1=17..24; `out_valid` pulses exactly once per 8 samples.
- **Backpressure:** hold `out_ready=0` after the first window and feed 17..24 → `in_ready=0` after sample 24; `A` unchanged; sample 25 is not accepted. Raise `out_ready` for one cycle → next cycle `A` row1=17..24, `out_valid=1`, `in_ready=1`.
- **Frame boundary:** `in_last` with sample 16, then new frame 101..116 → first window has `out_last=1`; the next window is 101..116 only, with no row from samples 1..16.
- **Misplaced `in_last`:** assert `in_last` with sample 5 → `err`=1 for one cycle; samples 1..5 discarded; next window appears only after 16 further samples.
